// File: rtl/sram22_pipelined_model.sv
// sram22_pipelined_model: parametrised behavioural model of an SRAM22 single-port macro.
// Adds a reset-driven fill of every word with INIT_VALUE (ready low until it finishes),
// a READ_LATENCY-deep read pipeline, and an rvalid strobe.
// Optional feature macro: SRAM22_WRITE_THROUGH_EN.
//   Defined   - accepted writes return the merged word on dout with rvalid after READ_LATENCY edges.
//   Undefined - accepted writes drive dout to X at the output stage; rvalid stays low.
module sram22_pipelined_model #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 12,
    parameter int unsigned           WRITE_SIZE   = 8,
    parameter int unsigned           READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    localparam int unsigned          WMASK_WIDTH  = DATA_WIDTH / WRITE_SIZE,
    localparam int unsigned          RAM_DEPTH    = 1 << ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    output logic                   ready,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   rvalid
);

    if (((DATA_WIDTH % WRITE_SIZE) != 0) || (READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_param_err
        $fatal(1, "sram22_pipelined_model: DATA_WIDTH must be a multiple of WRITE_SIZE and READ_LATENCY must be 1..4");
    end

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    ready_q;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    acc;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   wr_merged;

    // Stage-0 inputs, captured at the accept edge.
    logic                    in_v_d;
    logic                    in_w_d;
    logic [DATA_WIDTH-1:0]   in_data_d;

    // Signals feeding the output register (last internal stage, or stage-0 inputs when latency is 1).
    logic                    tail_v;
    logic                    tail_w;
    logic [DATA_WIDTH-1:0]   tail_d;

    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   dout_q;

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign dout   = dout_q;

    // ready_q is only high in IDLE, so it alone qualifies an accept.
    assign acc     = req && ready_q;
    assign rd_word = mem[addr];

    // Merge write-enabled lanes of din over the currently stored word.
    always_comb begin
        wr_merged = rd_word;
        for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
            if (wmask[i]) begin
                wr_merged[i*WRITE_SIZE +: WRITE_SIZE] = din[i*WRITE_SIZE +: WRITE_SIZE];
            end
        end
    end

    // Build the stage-0 record for an accepted operation.
    always_comb begin
        in_v_d    = acc && !we;
        in_w_d    = acc && we;
        in_data_d = we ? wr_merged : rd_word;
    end

    // Init sequencer: walk every address once after reset, then raise ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
            end
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Storage array: init fill and masked writes; contents survive reset until refilled.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[cnt_q] <= INIT_VALUE;
        end else if (in_w_d) begin
            mem[addr] <= wr_merged;
        end
    end

    if (READ_LATENCY == 1) begin : g_direct
        assign tail_v = in_v_d;
        assign tail_w = in_w_d;
        assign tail_d = in_data_d;
    end else begin : g_pipe
        localparam int unsigned NSTG = READ_LATENCY - 1;

        logic [NSTG-1:0]       v_q;
        logic [NSTG-1:0]       w_q;
        logic [DATA_WIDTH-1:0] d_q [NSTG];

        // Intermediate stages: shift valid, write-flag and data one stage per edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= '0;
                w_q <= '0;
                for (int unsigned i = 0; i < NSTG; i++) begin
                    d_q[i] <= '0;
                end
            end else begin
                v_q[0] <= in_v_d;
                w_q[0] <= in_w_d;
                d_q[0] <= in_data_d;
                for (int unsigned i = 1; i < NSTG; i++) begin
                    v_q[i] <= v_q[i-1];
                    w_q[i] <= w_q[i-1];
                    d_q[i] <= d_q[i-1];
                end
            end
        end

        assign tail_v = v_q[NSTG-1];
        assign tail_w = w_q[NSTG-1];
        assign tail_d = d_q[NSTG-1];
    end

    // Output stage: dout only moves for a completing op, otherwise it holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            dout_q   <= '0;
        end else begin
`ifdef SRAM22_WRITE_THROUGH_EN
            rvalid_q <= tail_v || tail_w;
            if (tail_v || tail_w) begin
                dout_q <= tail_d;
            end
`else
            rvalid_q <= tail_v;
            if (tail_v) begin
                dout_q <= tail_d;
            end else if (tail_w) begin
                dout_q <= 'x;
            end
`endif
        end
    end

endmodule

// File: doc/sram22_pipelined_model.md
Name: sram22_pipelined_model

Overview:
- Parametrised behavioural model of an SRAM22 single-port macro; next generation of the fixed-size SRAM22 simulation models.
- Generalises word width, depth and write-mask granularity.
- Adds the following over the fixed-size models:
  - an async-reset-driven memory initialisation sequence with a ready handshake,
  - a configurable read-latency pipeline,
  - a read-valid strobe.
- Used in SoC-level simulation in place of each generated macro.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDR_WIDTH, 12, address bits; RAM_DEPTH = 2**ADDR_WIDTH words.
- WRITE_SIZE, 8, bits per write-mask lane; WMASK_WIDTH = DATA_WIDTH/WRITE_SIZE (derived, not overridable).
- READ_LATENCY, 1, clock edges from accepted read to dout/rvalid; legal range 1..4.
- INIT_VALUE, 0, word value written to every location during init; DATA_WIDTH wide.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  operation request.
- ready  output  1  high when the model accepts requests.
- we  input  1  1 = write, 0 = read; sampled with req.
- wmask  input  WMASK_WIDTH  per-lane write enable; lane i covers din[i*WRITE_SIZE +: WRITE_SIZE].
- addr  input  ADDR_WIDTH  word address.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  read data.
- rvalid  output  1  one-cycle strobe marking dout valid.

Behaviour:
- Reset (async assert, released on clk): ready=0, rvalid=0, dout=0, all pipeline stages cleared, state=INIT, init counter=0.
- Memory contents are not cleared asynchronously; INIT overwrites them.
- States:
  - INIT: each posedge writes INIT_VALUE to mem[cnt], then cnt++. On the edge writing RAM_DEPTH-1, go to IDLE.
  - IDLE: ready=1.
  - ready rises exactly RAM_DEPTH edges after rst deasserts.
- Accept = req && ready at posedge. In INIT, req is ignored: no memory change, no rvalid.
- Write accept: for each i with wmask[i]=1, mem[addr] lane i <= din lane i. Lanes with wmask[i]=0 are unchanged; wmask=0 is a no-op write.
- Read accept: mem[addr] is sampled at the accept edge. The value propagates through READ_LATENCY register stages; dout and rvalid=1 appear after READ_LATENCY edges.
- rvalid is high for exactly one cycle per accepted read.
- dout holds its last value while rvalid=0, except during writes; see Optional Feature.
- Fully pipelined: one op per cycle, back-to-back reads give consecutive rvalid strobes in order.
- Write then read of the same address on the next edge returns the updated word.
- Reads and writes interleave freely; the pipeline carries a per-stage valid bit and write-flag.
- Reset mid-operation:
  - in-flight reads are discarded, with no rvalid,
  - dout=0,
  - the INIT sequence restarts from cnt=0, including reset during INIT.
- Elaboration check: $fatal if DATA_WIDTH % WRITE_SIZE != 0 or READ_LATENCY is outside 1..4.

Optional Feature:
- Macro: SRAM22_WRITE_THROUGH_EN.
- Defined: an accepted write also travels the pipeline. After READ_LATENCY edges, dout = the post-write merged word and rvalid=1.
- Undefined: an accepted write drives dout to all-X at the final pipeline stage after READ_LATENCY edges, and rvalid stays 0. Output during writes is arbitrary, as on silicon.

Test Plan:
- Init check (ADDR_WIDTH=4, INIT_VALUE=32'hA5A5A5A5): release rst, hold req=1 we=0 addr=3.
  - ready stays 0 for 16 edges, then rises; no rvalid before ready.
  - First accepted read returns 32'hA5A5A5A5.
- Masked write (READ_LATENCY=1): write addr=5, din=32'h11223344, wmask=4'b1111; then write addr=5, din=32'hFFFFFFFF, wmask=4'b0101; then read addr 5.
  - Required: dout=32'h11FF33FF, rvalid high exactly one cycle after the read edge.
- Latency sweep (READ_LATENCY=3): reads to addrs 0,1,2 on consecutive edges after writing 10,20,30.
  - rvalid is high on edges 3,4,5 with dout=10,20,30 in order.
- Read-after-write: write addr=7 din=32'hDEADBEEF, read addr=7 on the next edge.
  - dout=32'hDEADBEEF, rvalid=1.
- Reset mid-flight (READ_LATENCY=2): issue a read, assert rst one edge later.
  - rvalid never pulses, dout=0, ready=0, INIT restarts.
  - All previously written words read back as INIT_VALUE.
- Write with macro undefined: a write produces dout=X and rvalid=0. With SRAM22_WRITE_THROUGH_EN defined, the same write produces dout=merged word and rvalid=1.
